// File: rtl/display_scanner_if.sv
// Digit sources, scan controls and display pins of the display scanner.
// The master side drives the digit registers; the slave side drives the pins.
interface display_scanner_if;
    logic [1:0] sel;
    logic [3:0] op1_d0, op1_d1, op1_d2, op1_d3;
    logic [3:0] op2_d0, op2_d1, op2_d2, op2_d3;
    logic [3:0] res_d0, res_d1, res_d2, res_d3;
    logic [1:0] cnt;
    logic       block;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output sel, op1_d0, op1_d1, op1_d2, op1_d3,
        output op2_d0, op2_d1, op2_d2, op2_d3,
        output res_d0, res_d1, res_d2, res_d3,
        output cnt, block,
        input  an, seg, dp
    );

    modport slave (
        input  sel, op1_d0, op1_d1, op1_d2, op1_d3,
        input  op2_d0, op2_d1, op2_d2, op2_d3,
        input  res_d0, res_d1, res_d2, res_d3,
        input  cnt, block,
        output an, seg, dp
    );
endinterface

// File: rtl/display_scanner.sv
// Time-multiplexed 4-digit seven-segment scanner with cursor, blink and
// leading-zero blanking; digit sources are frozen once per scan frame.
module display_scanner #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic              clk,
    input  logic              rst,
    display_scanner_if.slave  bus
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    typedef enum logic {BLANK, SCAN} state_t;

    state_t                state, state_nxt;
    logic [PW-1:0]         presc;
    logic [1:0]            idx, idx_nxt;
    logic                  tick, frame_start;
    logic [FW-1:0]         fcnt, fcnt_nxt;
    logic                  phase, phase_nxt;

    logic [1:0]            snap_sel, eff_sel;
    logic [1:0]            snap_cnt, eff_cnt;
    logic                  snap_block, eff_block;
    logic [3:0][3:0]       snap_op1, snap_op2, snap_res;
    logic [3:0][3:0]       live_op1, live_op2, live_res;
    logic [3:0][3:0]       eff_op1, eff_op2, eff_res;

    logic [3:0]            digit;
    logic [3:0]            an_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // True when every result digit from the MSD up to slot k is zero; slot 3 never blanks.
    function automatic logic lead_zero(input logic [3:0][3:0] d, input logic [1:0] k);
        logic z;
        z = (k != 2'd3);
        for (int i = 0; i < 3; i++)
            if (i <= int'(k) && d[i] != 4'd0) z = 1'b0;
        return z;
    endfunction

    assign tick     = (presc == PW'(REFRESH_DIV - 1));
    assign live_op1 = {bus.op1_d3, bus.op1_d2, bus.op1_d1, bus.op1_d0};
    assign live_op2 = {bus.op2_d3, bus.op2_d2, bus.op2_d1, bus.op2_d0};
    assign live_res = {bus.res_d3, bus.res_d2, bus.res_d1, bus.res_d0};

    always_ff @(posedge clk) begin
        if (rst) state <= BLANK;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        frame_start = 1'b0;
        if (tick) begin
            state_nxt   = SCAN;
            idx_nxt     = (state == BLANK) ? 2'd0 : idx + 2'd1;
            frame_start = (idx_nxt == 2'd0);
        end
    end

    // Slot 0 of a frame sees the values being latched on the same edge.
    always_comb begin
        eff_sel   = frame_start ? bus.sel   : snap_sel;
        eff_cnt   = frame_start ? bus.cnt   : snap_cnt;
        eff_block = frame_start ? bus.block : snap_block;
        eff_op1   = frame_start ? live_op1  : snap_op1;
        eff_op2   = frame_start ? live_op2  : snap_op2;
        eff_res   = frame_start ? live_res  : snap_res;
    end

    // A frame is counted only when the frame just completed was itself blocked.
    always_comb begin
        fcnt_nxt  = fcnt;
        phase_nxt = phase;
        if (frame_start) begin
            if (!bus.block) begin
                fcnt_nxt  = '0;
                phase_nxt = 1'b0;
            end else if (state == SCAN && snap_block) begin
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt_nxt  = '0;
                    phase_nxt = ~phase;
                end else begin
                    fcnt_nxt = fcnt + FW'(1);
                end
            end
        end
    end

    always_comb begin
        case (eff_sel)
            2'b01:   digit = eff_op2[idx_nxt];
            2'b10:   digit = eff_res[idx_nxt];
            default: digit = eff_op1[idx_nxt];
        endcase
        an_nxt  = ~(4'b1000 >> idx_nxt);
        seg_nxt = decode(digit);
        dp_nxt  = 1'b1;
        if (eff_sel == 2'b10 && lead_zero(eff_res, idx_nxt))
            seg_nxt = 7'h7F;
        if (!eff_sel[1]) begin
            if (!eff_block && eff_cnt == idx_nxt) dp_nxt = 1'b0;
            if (eff_block && phase_nxt) begin
                an_nxt  = 4'hF;
                seg_nxt = 7'h7F;
            end
        end
        if (eff_sel == 2'b11) begin
            an_nxt  = 4'hF;
            seg_nxt = 7'h7F;
            dp_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            idx        <= 2'd0;
            fcnt       <= '0;
            phase      <= 1'b0;
            snap_sel   <= 2'd0;
            snap_cnt   <= 2'd0;
            snap_block <= 1'b0;
            snap_op1   <= '0;
            snap_op2   <= '0;
            snap_res   <= '0;
            bus.an     <= 4'hF;
            bus.seg    <= 7'h7F;
            bus.dp     <= 1'b1;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            fcnt  <= fcnt_nxt;
            phase <= phase_nxt;
            if (tick) begin
                idx     <= idx_nxt;
                bus.an  <= an_nxt;
                bus.seg <= seg_nxt;
                bus.dp  <= dp_nxt;
            end
            if (frame_start) begin
                snap_sel   <= bus.sel;
                snap_cnt   <= bus.cnt;
                snap_block <= bus.block;
                snap_op1   <= live_op1;
                snap_op2   <= live_op2;
                snap_res   <= live_res;
            end
        end
    end
endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: stimulus queues per-slot expectations,
// a negedge monitor pops one per slot and checks it is held for the whole slot.
module tb_display_scanner;
    localparam int RD = 4;
    localparam int BF = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       chk_seg;
    } exp_t;

    localparam exp_t DARK = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, chk_seg: 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_seen = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t cur = DARK;

    display_scanner_if bus();

    display_scanner #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input exp_t e);
        checks++;
        if (bus.an !== e.an || (e.chk_seg && bus.seg !== e.seg) || bus.dp !== e.dp) begin
            errors++;
            $display("FAIL %s t=%0t got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                     name, $time, bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
        end
    endtask

    always @(posedge clk) rst_seen = rst;

    always @(negedge clk) begin
        if (rst_seen) begin
            cyc = 0;
            check("reset_dark", DARK);
        end else begin
            cyc++;
            if (cyc < RD) begin
                check("pre_first_slot", DARK);
            end else if (cyc % RD == 0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow t=%0t got empty queue expected an entry", $time);
                end else begin
                    cur = q.pop_front();
                    check("slot_entry", cur);
                end
            end else begin
                check("slot_hold", cur);
            end
        end
    end

    task automatic push(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                        input logic [6:0] s3, input logic [3:0] dpm, input logic lit,
                        input logic chk_seg, input int n);
        logic [6:0] s [4];
        logic [3:0] one_hot;
        exp_t e;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int k = 0; k < n; k++) begin
            one_hot   = 4'b1000 >> k;
            e.an      = lit ? ~one_hot : 4'hF;
            e.seg     = s[k];
            e.dp      = dpm[k];
            e.chk_seg = chk_seg;
            q.push_back(e);
        end
    endtask

    task automatic set_op1(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        bus.op1_d0 = a; bus.op1_d1 = b; bus.op1_d2 = c; bus.op1_d3 = d;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got no finish expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.sel = 2'b00; bus.cnt = 2'd0; bus.block = 1'b0;
        set_op1(4'd1, 4'd2, 4'd3, 4'd4);
        bus.op2_d0 = 4'd0; bus.op2_d1 = 4'd0; bus.op2_d2 = 4'd0; bus.op2_d3 = 4'd0;
        bus.res_d0 = 4'd0; bus.res_d1 = 4'd0; bus.res_d2 = 4'd0; bus.res_d3 = 4'd0;

        // F0, F1: op1 = 1,2,3,4 with cursor in slot 0
        push(7'h79, 7'h24, 7'h30, 7'h19, 4'b1110, 1'b1, 1'b1, 4);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_edges(RD);
        push(7'h79, 7'h24, 7'h30, 7'h19, 4'b1110, 1'b1, 1'b1, 4);
        wait_edges(4 * RD);

        // F2: result 0,0,4,2 with leading zeros blanked
        bus.sel = 2'b10;
        bus.res_d0 = 4'd0; bus.res_d1 = 4'd0; bus.res_d2 = 4'd4; bus.res_d3 = 4'd2;
        push(7'h7F, 7'h7F, 7'h19, 7'h24, 4'b1111, 1'b1, 1'b1, 4);
        wait_edges(4 * RD);

        // F3: all-zero result, only slot 3 lit with 0
        bus.res_d2 = 4'd0; bus.res_d3 = 4'd0;
        push(7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b1111, 1'b1, 1'b1, 4);
        wait_edges(4 * RD);

        // F4: op1 again; op1_d2 changes mid-frame and must not show until F5
        bus.sel = 2'b00;
        set_op1(4'd1, 4'd2, 4'd3, 4'd4);
        push(7'h79, 7'h24, 7'h30, 7'h19, 4'b1110, 1'b1, 1'b1, 4);
        wait_edges(4 * RD);
        wait_edges(RD + 1);
        bus.op1_d2 = 4'd7;
        bus.op1_d3 = 4'hA;
        push(7'h79, 7'h24, 7'h78, 7'h3F, 4'b1110, 1'b1, 1'b1, 4);
        wait_edges(3 * RD - 1);

        // F6: op2 = 5,6,8,9 with cursor in slot 2
        bus.sel = 2'b01; bus.cnt = 2'd2; bus.block = 1'b0;
        bus.op2_d0 = 4'd5; bus.op2_d1 = 4'd6; bus.op2_d2 = 4'd8; bus.op2_d3 = 4'd9;
        push(7'h12, 7'h02, 7'h00, 7'h10, 4'b1011, 1'b1, 1'b1, 4);
        wait_edges(4 * RD);

        // F7..F11: blocked operand blinks 2 frames on, 2 off
        bus.block = 1'b1;
        push(7'h12, 7'h02, 7'h00, 7'h10, 4'b1111, 1'b1, 1'b1, 4);
        wait_edges(4 * RD);
        push(7'h12, 7'h02, 7'h00, 7'h10, 4'b1111, 1'b1, 1'b1, 4);
        wait_edges(4 * RD);
        push(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111, 1'b0, 1'b0, 4);
        wait_edges(4 * RD);
        push(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111, 1'b0, 1'b0, 4);
        wait_edges(4 * RD);
        push(7'h12, 7'h02, 7'h00, 7'h10, 4'b1111, 1'b1, 1'b1, 4);
        wait_edges(4 * RD);

        // F12: display off
        bus.sel = 2'b11;
        push(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111, 1'b0, 1'b1, 4);
        wait_edges(4 * RD);

        // F13: op1 1,2,3,4 interrupted by reset during slot 2
        bus.sel = 2'b00; bus.cnt = 2'd0; bus.block = 1'b0;
        set_op1(4'd1, 4'd2, 4'd3, 4'd4);
        push(7'h79, 7'h24, 7'h30, 7'h19, 4'b1110, 1'b1, 1'b1, 3);
        wait_edges(4 * RD);
        wait_edges(2 * RD);
        rst = 1'b1;
        push(7'h79, 7'h24, 7'h30, 7'h19, 4'b1110, 1'b1, 1'b1, 4);
        wait_edges(2);
        rst = 1'b0;
        wait_edges(RD);

        // Scanning continues with sel=11 and stays dark
        bus.sel = 2'b11;
        push(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111, 1'b0, 1'b1, 4);
        wait_edges(4 * RD);
        wait_edges(4 * RD);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed 4-digit seven-segment driver for the calculator's read side. It takes the BCD digit registers of operand 1, operand 2 and the result, selects one source, and scans its digits onto a common-anode 4-digit display. It marks the entry cursor, blinks a full (blocked) operand, and blanks leading zeros of the result. It sits between the operand/result storage and the board display pins, as the consumer of the digit registers that the keypad path fills.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- BLINK_FRAMES, 32: full scan frames per blink half-period; must be ≥ 1.

- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- sel  in  2  source: 00 op1, 01 op2, 10 result, 11 display off.
- op1_d0..op1_d3  in  4 each  operand 1 BCD digits; d0 = first entered = leftmost.
- op2_d0..op2_d3  in  4 each  operand 2 BCD digits, same ordering.
- res_d0..res_d3  in  4 each  result BCD digits, d0 most significant.
- cnt  in  2  index of the digit slot carrying the entry cursor.
- block  in  1  operand full/locked; enables blinking.
- an  out  4  digit anodes, active-low; an[3] = leftmost.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; used as cursor.

## Operation
- States:
  - BLANK: entered on reset; display dark.
  - SCAN: entered on the first tick and never left except by rst.
- Prescaler `presc` counts 0..REFRESH_DIV-1 and wraps. `tick` = (presc == REFRESH_DIV-1).
- Slot index `idx`, 2 bits:
  - BLANK→SCAN on tick sets idx=0.
  - In SCAN, each tick advances idx by 1 modulo 4.
  - Slot k drives an[3-k] low and shows digit d_k.
- Frame snapshot:
  - On every tick where the new idx is 0, register sel, cnt, block and the 12 digit inputs.
  - Slots 0..3 of that frame use the snapshot. Slot 0 uses the values being latched at that same edge.
- Decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Values A–F display a dash: 0111111.
- Leading-zero blanking, sel=10 only:
  - Slot k<3 shows seg=1111111 when res_d0..res_d_k are all 0. The anode is still driven.
  - Slot 3 is never blanked.
- Cursor, sel=00/01 with block=0 only: dp=0 in the slot whose idx equals snapshot cnt. Otherwise dp=1.
- Blink, sel=00/01 with block=1:
  - Frame counter counts completed frames. Blink phase toggles every BLINK_FRAMES frames.
  - Phase 1 (off): an=1111.
  - The phase counter and frame counter clear on any frame whose snapshot has block=0. The first blocked frame is therefore always "on".
- sel=11: an=1111, seg=1111111, dp=1 for the whole frame. Scanning continues.

## Timing
- Reset values: an=1111, seg=1111111, dp=1, state BLANK, presc=0, idx=0, blink phase 0, frame counter 0, snapshot all 0.
- rst is sampled at the clk edge and takes priority over everything, including mid-frame. Outputs go dark on the edge where rst is seen high. Scanning restarts from BLANK.
- an, seg and dp are registers. They change only on a tick edge and carry the values for the new idx, so there is no intermediate glitch value.
- First lit slot appears on the REFRESH_DIV-th rising edge after rst is deasserted.
- Each slot lasts exactly REFRESH_DIV cycles. One frame = 4·REFRESH_DIV cycles.
- Input changes (digits, sel, cnt, block) are ignored until the next frame start. Worst-case visibility latency is 4·REFRESH_DIV cycles.

## Test plan
- Reset and first slot (REFRESH_DIV=4):
  - Stimulus: rst high 3 cycles, sel=00, op1=1,2,3,4.
  - Response: an=1111, seg=1111111, dp=1 until the 4th edge after release; then an=0111, seg=1111001.
- Full frame scan:
  - Stimulus: same setup, continued.
  - Response: (an,seg) = (0111,1111001), (1011,0100100), (1101,0110000), (1110,0011001), each held 4 cycles, then repeats.
- Result blanking, sel=10:
  - Stimulus: res=0,0,4,2.
  - Response: slots 0 and 1 give seg=1111111; slot 2 gives 0011001; slot 3 gives 0100100.
  - Stimulus: res=0,0,0,0.
  - Response: only slot 3 shows 1000000.
- Frame coherence:
  - Stimulus: change op1_d2 from 3 to 7 while idx=1.
  - Response: slot 2 still shows 0110000 this frame and 1111000 next frame. An input of 4'hA shows 0111111.
- Cursor and blink (BLINK_FRAMES=2):
  - Stimulus: sel=01, block=0, cnt=2.
  - Response: dp=0 only in slot 2.
  - Stimulus: set block=1.
  - Response: 2 frames lit, 2 frames an=1111, alternating; dp=1 throughout.
- Reset mid-frame and sel=11:
  - Stimulus: assert rst during slot 2.
  - Response: dark on that edge; first slot again REFRESH_DIV edges after release.
  - Stimulus: sel=11.
  - Response: an stays 1111 for all slots.
